viterbi_tbu: RTL and testbench
==============================

# viterbi_tbu

Survivor-path / decision-output stage of a rate-1/2, K=3 (4-state) Viterbi decoder, using register exchange. Each valid step it takes the four add-compare-select (ACS) decision bits and the four new path metrics from the ACS stage. It updates one survivor register per state and emits one decoded bit from the best-metric state, delayed by a fixed traceback depth. It sits directly after the ACS/path-metric unit and drives the decoder's output bit stream.

## Interface
- TBL, 15 — traceback depth in trellis steps; also the fill count before the first valid output.
- PM_W, 8 — path-metric width, unsigned.
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — asynchronous, active-high reset.
- valid_i  in  1  — one trellis step is presented this cycle.
- dec_bits_i  in  4  — ACS decision per new state s (bit s): 0 selects the even predecessor, 1 the odd predecessor.
- pm_new_s0_i .. pm_new_s3_i  in  PM_W each  — new path metrics of states 0..3 for this step.
- decoded_bit_o  out  1  — decoded information bit, registered.
- valid_o  out  1  — decoded_bit_o is valid this cycle, registered.

## Operation
- State numbering: s = {s[1], s[0]}, where s[1] is the newest input bit. Transition is s → {u, s[1]}.
- Predecessor of new state ns: p = {ns[0], dec_bits_i[ns]} = 2*ns[0] + dec_bits_i[ns].
- Input bit on the branch into ns = ns[1]. States 0 and 1 append 0; states 2 and 3 append 1.
- Survivor registers: surv[0..3], each TBL+1 bits wide. The MSB is the oldest bit.
- On a valid step: next_surv[ns] = {surv[p][TBL-1:0], ns[1]}. All four states update simultaneously from the old values.
- Winner = state with minimum pm_new_*_i, compared unsigned. On a tie the lowest index wins (S0 > S1 > S2 > S3).
- On a valid step: decoded_bit_o <= next_surv[winner][TBL]. This is the bit decided TBL steps before the current step.
- Fill counter:
  - counts valid steps and saturates at TBL;
  - a pipeline_full flag sets on the edge where the count reaches TBL and stays set until reset.
- valid_o <= valid_i & pipeline_full, where pipeline_full is the value before the edge.
- With valid_i = 0:
  - survivors, counter, pipeline_full and decoded_bit_o hold;
  - valid_o <= 0.
- dec_bits_i and the PM inputs are ignored when valid_i = 0.

## Timing
- Reset (asynchronous, immediate): all surv = 0, counter = 0, pipeline_full = 0, decoded_bit_o = 0, valid_o = 0.
- Output latency:
  - valid_o first rises after the edge of valid step TBL+1 (the 16th by default); it is low after steps 1..TBL;
  - the decoded bit for valid step k appears after the edge of valid step k+TBL.
- Steady state: one output per valid input, registered one clock after valid_i is sampled. Gaps in valid_i produce matching gaps in valid_o; no other stall or backpressure.
- Counter saturation: no wrap-around. After fill, valid_o tracks valid_i indefinitely.
- Winner selection and survivor update are combinational within the cycle; there is no extra pipeline stage.
- Reset asserted mid-stream: everything clears. After release, a full TBL-step refill is required before valid_o returns.
- Simultaneous reset and valid_i: reset dominates.

## Test plan
- Reset: rst high then low, valid_i = 0 → valid_o = 0, decoded_bit_o = 0.
- Fill/latency:
  - stimulus: valid_i = 1, dec_bits_i = 4'b0000, PMs S0 = 0 and S1..S3 = 10;
  - after the 15th edge → valid_o = 0;
  - after the 16th edge → valid_o = 1, decoded_bit_o = 0.
- All-ones path:
  - stimulus: from reset, valid_i = 1, dec_bits_i = 4'b1000 (S3 self-loop), PMs S3 = 0 and others = 10, for 16 steps → valid_o = 1, decoded_bit_o = 1;
  - continue with valid_i held → decoded_bit_o stays 1.
- Non-winner path:
  - stimulus: dec_bits_i = 4'b0000 for 20 steps with S3 as winner → decoded_bit_o = 0, because the S3 survivor is …0011 and its MSB is 0.
- Valid gating:
  - after fill, drop valid_i for 1 cycle → valid_o = 0 and decoded_bit_o unchanged;
  - reassert → valid_o = 1 on the next edge, with no refill.
- Tie-break and mid-stream reset:
  - all PMs equal → output follows S0;
  - pulse rst mid-stream → valid_o low for the next 15 valid steps, high on the 16th.

Source files
------------

// File: rtl/viterbi_tbu.sv
// Register-exchange survivor memory and decision output for a 4-state (K=3) Viterbi decoder.
// Emits the bit decided TBL steps ago on the minimum-metric survivor path.
module viterbi_tbu #(
    parameter int TBL  = 15,
    parameter int PM_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [3:0]      dec_bits_i,
    input  logic [PM_W-1:0] pm_new_s0_i,
    input  logic [PM_W-1:0] pm_new_s1_i,
    input  logic [PM_W-1:0] pm_new_s2_i,
    input  logic [PM_W-1:0] pm_new_s3_i,
    output logic            decoded_bit_o,
    output logic            valid_o
);

    localparam int CNT_W = $clog2(TBL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TBL);

    logic [TBL:0]     surv_q [4];
    logic [TBL:0]     surv_d [4];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             bit_q, bit_d;
    logic             vld_q, vld_d;
    logic [1:0]       winner;

    // Strict less-than keeps the lower index on ties.
    function automatic logic [1:0] min_state(input logic [PM_W-1:0] m0, input logic [PM_W-1:0] m1,
                                             input logic [PM_W-1:0] m2, input logic [PM_W-1:0] m3);
        logic [1:0]      idx;
        logic [PM_W-1:0] best;
        idx  = 2'd0;
        best = m0;
        if (m1 < best) begin idx = 2'd1; best = m1; end
        if (m2 < best) begin idx = 2'd2; best = m2; end
        if (m3 < best) begin idx = 2'd3; end
        return idx;
    endfunction

    always_comb begin
        winner = min_state(pm_new_s0_i, pm_new_s1_i, pm_new_s2_i, pm_new_s3_i);
        for (int ns = 0; ns < 4; ns++) begin
            surv_d[ns] = surv_q[ns];
            if (valid_i) begin
                surv_d[ns] = {surv_q[2 * (ns % 2) + int'(dec_bits_i[ns])][TBL-1:0], ns[1]};
            end
        end
        cnt_d  = cnt_q;
        bit_d  = bit_q;
        if (valid_i) begin
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
            bit_d = surv_d[winner][TBL];
        end
        full_d = full_q | (cnt_d == CNT_FULL);
        vld_d  = valid_i & full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 4; s++) surv_q[s] <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
            bit_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            for (int s = 0; s < 4; s++) surv_q[s] <= surv_d[s];
            cnt_q  <= cnt_d;
            full_q <= full_d;
            bit_q  <= bit_d;
            vld_q  <= vld_d;
        end
    end

    assign decoded_bit_o = bit_q;
    assign valid_o       = vld_q;

endmodule

// File: tb/tb_viterbi_tbu.sv
// Bench for viterbi_tbu: directed vector table, mid-stream reset sequence, and random
// stimulus checked against a traceback-based reference model.
module tb_viterbi_tbu;

    localparam int TBL  = 15;
    localparam int PM_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            valid_i = 1'b0;
    logic [3:0]      dec_bits_i = '0;
    logic [PM_W-1:0] pm0 = '0, pm1 = '0, pm2 = '0, pm3 = '0;
    logic            decoded_bit_o, valid_o;

    viterbi_tbu #(.TBL(TBL), .PM_W(PM_W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .dec_bits_i(dec_bits_i),
        .pm_new_s0_i(pm0), .pm_new_s1_i(pm1), .pm_new_s2_i(pm2), .pm_new_s3_i(pm3),
        .decoded_bit_o(decoded_bit_o), .valid_o(valid_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: history of decision words, traced back from the winner on each step.
    int   mq[$];
    int   m_n = 0;
    logic m_bit = 1'b0;
    logic m_vld = 1'b0;

    typedef struct {
        string    name;
        bit       do_reset;
        bit       v;
        bit [3:0] dec;
        int       p0, p1, p2, p3;
        int       n;
        bit       exp_vld;
        bit       exp_bit;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int argmin(input int a, input int b, input int c, input int d);
        int m[4];
        int w;
        m = '{a, b, c, d};
        w = 0;
        for (int i = 1; i < 4; i++) if (m[i] < m[w]) w = i;
        return w;
    endfunction

    task automatic model_step(input bit v, input bit [3:0] d, input int a, input int b,
                              input int c, input int e);
        int s;
        m_vld = v && (m_n >= TBL);
        if (v) begin
            mq.push_back(int'(d));
            m_n++;
            if (m_n - TBL < 1) begin
                m_bit = 1'b0;
            end else begin
                s = argmin(a, b, c, e);
                for (int k = m_n; k > m_n - TBL; k--) s = 2 * (s % 2) + ((mq[k-1] >> s) & 1);
                m_bit = logic'((s >> 1) & 1);
            end
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_n   = 0;
        m_bit = 1'b0;
        m_vld = 1'b0;
    endtask

    task automatic do_step(input bit v, input bit [3:0] d, input int a, input int b,
                           input int c, input int e);
        valid_i    = v;
        dec_bits_i = d;
        pm0 = PM_W'(a); pm1 = PM_W'(b); pm2 = PM_W'(c); pm3 = PM_W'(e);
        @(posedge clk);
        model_step(v, d, a, b, c, e);
        #1;
        chk("model_vld", valid_o, m_vld);
        chk("model_bit", decoded_bit_o, m_bit);
    endtask

    // Reset is held across a clock edge with valid_i high so that reset must dominate.
    task automatic apply_reset();
        valid_i    = 1'b1;
        dec_bits_i = 4'($urandom);
        rst = 1'b1;
        #2;
        chk("rst_async_vld", valid_o, 1'b0);
        chk("rst_async_bit", decoded_bit_o, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_hold_vld", valid_o, 1'b0);
        chk("rst_hold_bit", decoded_bit_o, 1'b0);
        @(negedge clk);
        rst     = 1'b0;
        valid_i = 1'b0;
        model_reset();
    endtask

    initial begin
        tbl.push_back('{"fill15",      1, 1, 4'b0000,  0, 10, 10, 10, 15, 0, 0});
        tbl.push_back('{"fill16",      0, 1, 4'b0000,  0, 10, 10, 10,  1, 1, 0});
        tbl.push_back('{"ones15",      1, 1, 4'b1000, 10, 10, 10,  0, 15, 0, 0});
        tbl.push_back('{"ones16",      0, 1, 4'b1000, 10, 10, 10,  0,  1, 1, 1});
        tbl.push_back('{"ones_hold",   0, 1, 4'b1000, 10, 10, 10,  0,  5, 1, 1});
        tbl.push_back('{"gap",         0, 0, 4'b0110,  3,  2,  1,  0,  1, 0, 1});
        tbl.push_back('{"regain",      0, 1, 4'b1000, 10, 10, 10,  0,  1, 1, 1});
        tbl.push_back('{"nonwinner",   0, 1, 4'b0000, 10, 10, 10,  0, 20, 1, 0});
        tbl.push_back('{"s0_fill",     1, 1, 4'b1000,  0, 10, 10, 10, 16, 1, 0});
        tbl.push_back('{"s3_wins",     0, 1, 4'b1000,  9,  9,  9,  3,  1, 1, 1});
        tbl.push_back('{"tie_all",     0, 1, 4'b1000,  7,  7,  7,  7,  1, 1, 0});
        tbl.push_back('{"tie_s2_s3",   0, 1, 4'b1000,  9,  9,  3,  3,  1, 1, 0});
        tbl.push_back('{"s3_again",    0, 1, 4'b1000,  9,  9,  9,  3,  1, 1, 1});

        #1;
        apply_reset();
        @(posedge clk);
        #1;
        chk("reset_idle_vld", valid_o, 1'b0);
        chk("reset_idle_bit", decoded_bit_o, 1'b0);

        foreach (tbl[i]) begin
            if (tbl[i].do_reset) apply_reset();
            for (int k = 0; k < tbl[i].n; k++)
                do_step(tbl[i].v, tbl[i].dec, tbl[i].p0, tbl[i].p1, tbl[i].p2, tbl[i].p3);
            chk({tbl[i].name, "_vld"}, valid_o, tbl[i].exp_vld);
            chk({tbl[i].name, "_bit"}, decoded_bit_o, tbl[i].exp_bit);
        end

        // Mid-stream reset after a steady stream: a full refill is needed before valid_o returns.
        for (int k = 0; k < 20; k++) do_step(1'b1, 4'b1000, 10, 10, 10, 0);
        apply_reset();
        for (int k = 1; k <= TBL + 1; k++) begin
            do_step(1'b1, 4'b1000, 10, 10, 10, 0);
            chk($sformatf("refill_vld_%0d", k), valid_o, (k == TBL + 1));
        end
        chk("refill_bit", decoded_bit_o, 1'b1);

        // Random stream with gaps, narrow metric range for frequent ties, one reset in the middle.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) apply_reset();
            do_step($urandom_range(0, 9) < 8, 4'($urandom),
                    $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
